// File: rtl/sc_downcounter_pkg.sv
// Shared FSM encodings for the loadable down transition counter.
package sc_downcounter_pkg;

  typedef logic [1:0] sc_state_t;

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] COUNTING = 2'b01;
  localparam logic [1:0] EXPIRED  = 2'b10;

endpackage

// File: rtl/sc_fall_edge_detect.sv
// Falling-edge detector with optional 2-flop input synchronizer.
// Macro SC_DOWNCOUNT_SYNC_EN enables the synchronizer (adds 2 cycles of latency).
module sc_fall_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic edge_o
);

  logic cur;
  logic prev_q;

`ifdef SC_DOWNCOUNT_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Both stages idle high so a released button never looks like an edge out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

  assign cur = sync2_q;
`else
  assign cur = din_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= cur;
    end
  end

  assign edge_o = prev_q & ~cur;

endmodule

// File: rtl/sc_down_transition_counter.sv
// Loadable down-counter of falling transitions on an active-low strobe; flags expiry once.
// Macro SC_DOWNCOUNT_SYNC_EN adds an input synchronizer on the downcount strobe.
module sc_down_transition_counter
  import sc_downcounter_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 SC_downTRANSITIONCOUNTER_CLOCK_50,
  input  logic                 SC_downTRANSITIONCOUNTER_RESET_InLow,
  input  logic                 SC_downTRANSITIONCOUNTER_load_InLow,
  input  logic [DATAWIDTH-1:0] SC_downTRANSITIONCOUNTER_load_InBUS,
  input  logic                 SC_downTRANSITIONCOUNTER_downcount_InLow,
  input  logic                 SC_downTRANSITIONCOUNTER_clear_InLow,
  output logic [DATAWIDTH-1:0] SC_downTRANSITIONCOUNTER_data_OutBUS,
  output logic                 SC_downTRANSITIONCOUNTER_zero_Out,
  output logic                 SC_downTRANSITIONCOUNTER_expired_Out
);

  localparam logic [DATAWIDTH-1:0] CNT_ZERO = '0;
  localparam logic [DATAWIDTH-1:0] CNT_ONE  = DATAWIDTH'(1);

  sc_state_t            state_q, state_d;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic                 expired_q, expired_d;
  logic                 fall_edge;

  sc_fall_edge_detect u_edge (
    .clk_i  (SC_downTRANSITIONCOUNTER_CLOCK_50),
    .rst_ni (SC_downTRANSITIONCOUNTER_RESET_InLow),
    .din_i  (SC_downTRANSITIONCOUNTER_downcount_InLow),
    .edge_o (fall_edge)
  );

  // clear > load > decrement; an edge that loses priority is simply dropped.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (!SC_downTRANSITIONCOUNTER_clear_InLow) begin
      count_d = CNT_ZERO;
      state_d = IDLE;
    end else if (!SC_downTRANSITIONCOUNTER_load_InLow) begin
      count_d = SC_downTRANSITIONCOUNTER_load_InBUS;
      state_d = (SC_downTRANSITIONCOUNTER_load_InBUS == CNT_ZERO) ? IDLE : COUNTING;
    end else if (fall_edge && (state_q == COUNTING)) begin
      count_d = count_q - CNT_ONE;
      if (count_q == CNT_ONE) begin
        state_d   = EXPIRED;
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SC_downTRANSITIONCOUNTER_CLOCK_50 or negedge SC_downTRANSITIONCOUNTER_RESET_InLow) begin
    if (!SC_downTRANSITIONCOUNTER_RESET_InLow) begin
      state_q   <= IDLE;
      count_q   <= CNT_ZERO;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign SC_downTRANSITIONCOUNTER_data_OutBUS = count_q;
  assign SC_downTRANSITIONCOUNTER_zero_Out    = (count_q == CNT_ZERO);
  assign SC_downTRANSITIONCOUNTER_expired_Out = expired_q;

endmodule

// File: tb/tb_sc_down_transition_counter.sv
// Directed self-checking bench for sc_down_transition_counter (macro on or off).
module tb_sc_down_transition_counter;

`ifdef SC_DOWNCOUNT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_n = 1'b1;
  logic [7:0] load_bus = 8'd0;
  logic       dc_n = 1'b1;
  logic       clear_n = 1'b1;
  logic [7:0] data;
  logic       zero;
  logic       expired;

  int compared = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  sc_down_transition_counter #(.DATAWIDTH(8)) dut (
    .SC_downTRANSITIONCOUNTER_CLOCK_50        (clk),
    .SC_downTRANSITIONCOUNTER_RESET_InLow     (rst_n),
    .SC_downTRANSITIONCOUNTER_load_InLow      (load_n),
    .SC_downTRANSITIONCOUNTER_load_InBUS      (load_bus),
    .SC_downTRANSITIONCOUNTER_downcount_InLow (dc_n),
    .SC_downTRANSITIONCOUNTER_clear_InLow     (clear_n),
    .SC_downTRANSITIONCOUNTER_data_OutBUS     (data),
    .SC_downTRANSITIONCOUNTER_zero_Out        (zero),
    .SC_downTRANSITIONCOUNTER_expired_Out     (expired)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_n = 1'b0;
    load_bus = v;
    tick();
    load_n = 1'b1;
  endtask

  // Falling edge on downcount; returns after the count has had time to update.
  task automatic press();
    dc_n = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic release_dc();
    dc_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #25;
    chk("rst_data", int'(data), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_expired", int'(expired), 0);
    rst_n = 1'b1;
    tick();

    // T1: load 3, three presses -> 2,1,0 with a single expiry pulse
    do_load(8'd3);
    chk("t1_load", int'(data), 3);
    chk("t1_load_zero", int'(zero), 0);
    press();
    chk("t1_cnt2", int'(data), 2);
    chk("t1_exp_at2", int'(expired), 0);
    release_dc();
    press();
    chk("t1_cnt1", int'(data), 1);
    release_dc();
    press();
    chk("t1_cnt0", int'(data), 0);
    chk("t1_exp_pulse", int'(expired), 1);
    chk("t1_zero", int'(zero), 1);
    tick();
    chk("t1_exp_end", int'(expired), 0);
    release_dc();

    // T2: EXPIRED ignores further edges, no wrap
    press();
    chk("t2_nowrap", int'(data), 0);
    chk("t2_no_pulse", int'(expired), 0);
    tick();
    chk("t2_no_pulse2", int'(expired), 0);
    release_dc();

    // T3: held low counts once
    do_load(8'd5);
    press();
    chk("t3_first", int'(data), 4);
    repeat (10 - LAT) tick();
    chk("t3_held", int'(data), 4);
    release_dc();
    press();
    chk("t3_repress", int'(data), 3);
    release_dc();

    // T4: load in the same cycle as an edge -> load wins, edge discarded
    dc_n = 1'b0;
    repeat (LAT - 1) tick();
    load_n = 1'b0;
    load_bus = 8'd7;
    tick();
    load_n = 1'b1;
    chk("t4_load7", int'(data), 7);
    repeat (3) tick();
    chk("t4_edge_lost", int'(data), 7);
    release_dc();
    press();
    chk("t4_counting", int'(data), 6);
    release_dc();

    // T5: clear beats load
    do_load(8'd4);
    chk("t5_load4", int'(data), 4);
    clear_n = 1'b0;
    load_n = 1'b0;
    load_bus = 8'd9;
    tick();
    clear_n = 1'b1;
    load_n = 1'b1;
    chk("t5_clear", int'(data), 0);
    chk("t5_zero", int'(zero), 1);
    chk("t5_no_pulse", int'(expired), 0);
    press();
    chk("t5_idle_ign", int'(data), 0);
    chk("t5_idle_nopls", int'(expired), 0);
    release_dc();

    // Load of zero goes idle with no pulse
    do_load(8'd0);
    chk("ld0_data", int'(data), 0);
    chk("ld0_nopulse", int'(expired), 0);

    // T6: async reset between clocks
    do_load(8'd2);
    press();
    chk("t6_cnt1", int'(data), 1);
    release_dc();
    #4;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", int'(data), 0);
    chk("t6_rst_zero", int'(zero), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset kills a pulse in flight
    do_load(8'd1);
    press();
    chk("t6_pulse", int'(expired), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_pulse_kill", int'(expired), 0);
    dc_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_after", int'(data), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
